draw_player_rect: RTL and testbench
===================================

# draw_player_rect

Renders the player rectangle into the VGA pixel stream. It sits directly downstream of `draw_rect_ctl`, taking its `ypos` and `endgame` outputs, and sits in series on the timing/RGB chain between the background stage and the VGA output. The vertical position is sampled once per frame, at the start of vertical blanking, so the rectangle never tears. In the end-game state the rectangle blinks in the end-game colour.

## Interface
Parameters:
- `XPOS`, 100: left column of the rectangle, fixed.
- `RECT_W`, 32: width in pixels.
- `RECT_H`, 24: height in pixels.
- `COLOR_RECT`, 12'hFF0: fill colour during normal play.
- `COLOR_END`, 12'hF00: fill colour in the end-game state.
- `BLINK_FRAMES`, 30: frames per blink half-period, at least 1.

Ports:
- `clk` input 1: pixel clock, the single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `ypos` input 12: top row requested by `draw_rect_ctl`.
- `endgame` input 1: level signal; 1 selects blink mode.
- `hcount_in`, `vcount_in` input 11 each: pixel coordinates.
- `hsync_in`, `hblnk_in`, `vsync_in`, `vblnk_in` input 1 each: timing strobes.
- `rgb_in` input 12: upstream pixel colour.
- `hcount_out`, `vcount_out` output 11 each: coordinates delayed by 2 cycles.
- `hsync_out`, `hblnk_out`, `vsync_out`, `vblnk_out` output 1 each: strobes delayed by 2 cycles.
- `rgb_out` output 12: composited pixel.
- `frame_ypos` output 12: currently latched, clamped top row.

## Operation
**Frame latch**
- `vblnk_start` = `vblnk_in` & ~`vblnk_in` registered from the previous cycle.
- On `vblnk_start`, `frame_ypos` is loaded with min(`ypos`, `VER_PIXELS`-`RECT_H`).
- The comparison is 12-bit unsigned; `VER_PIXELS` comes from `vga_pkg`.
- Between `vblnk_start` events, `frame_ypos` holds.

**Hit test (stage 1)**
- `hit` = `hcount_in` in [`XPOS`, `XPOS`+`RECT_W`-1] and `vcount_in` in [`frame_ypos`, `frame_ypos`+`RECT_H`-1].
- `hit` is also gated by ~`hblnk_in` & ~`vblnk_in`.
- Count inputs are zero-extended to 12 bits; the inclusive bounds are computed in 12 bits with no overflow, because the clamp guarantees this.

**Colour select (stage 2)**
- `hit` & `show`: `rgb_out` = `fill`.
- Otherwise `rgb_out` = `rgb_in` delayed by 2 cycles.
- `fill` = `COLOR_END` when `endgame`=1, else `COLOR_RECT`.

**Blink FSM, two states**
- States: VISIBLE and HIDDEN; `show` = (state==VISIBLE).
- `frame_cnt` counts `vblnk_start` events while `endgame`=1.
- When `frame_cnt`==`BLINK_FRAMES`-1 at a `vblnk_start`: clear `frame_cnt` and toggle the state.
- While `endgame`=0: state is forced to VISIBLE and `frame_cnt` to 0, every cycle.
- Blink changes occur only at frame boundaries, never mid-frame.

**Simultaneous events**
- `endgame` rising on the same cycle as `vblnk_start`: the latch occurs, and `frame_cnt` becomes 1.
- `endgame` falling: VISIBLE with `COLOR_RECT` starts on the next cycle.

## Timing
- Latency from `*_in` to `*_out` is exactly 2 cycles for every timing and RGB signal.
- `frame_ypos` updates one cycle after the `vblnk_in` rising edge is presented.
- Reset values:
  - All `*_out` = 0 and `frame_ypos` = 0.
  - Blink state VISIBLE, `frame_cnt` = 0.
  - Previous-`vblnk` register = 0. Consequently, `vblnk_in`=1 in the first cycle after reset counts as `vblnk_start`.
- Reset asserted mid-frame: the pipeline is flushed to zeros within 1 cycle, and no partial rectangle is drawn.

## Structure
- `vga_pkg`: `VER_PIXELS` and `HOR_PIXELS` are already there.
- Add to `vga_pkg`:
  - `COLOR_RECT_DEF` and `COLOR_END_DEF`.
  - Typedef `blink_state_t` {VISIBLE, HIDDEN}.
- Sub-module `vga_delay` (parameter `DEPTH`=2): a shift register for the 4 strobes, 2 counts and `rgb`, for reuse by other draw stages.

## Test plan
- Reset, then `ypos`=200 and one frame run → `frame_ypos`=200; `rgb_out`=12'hFF0 exactly for `hcount` 100..131, `vcount` 200..223; output equals `rgb_in` elsewhere; 2-cycle alignment checked against the `hcount_out` delay.
- `ypos`=700 (>`VER_PIXELS`-24) → `frame_ypos`=`VER_PIXELS`-24, and the rectangle bottom is on the last visible row.
- `ypos` changes 200→300 mid-frame (`vcount`=210) → the current frame is still drawn at 200, and the next frame at 300.
- `endgame`=1, `BLINK_FRAMES`=2 → the rectangle is 12'hF00 for frames 0–1, absent for frames 2–3, and 12'hF00 again for frames 4–5.
- `endgame` dropped while HIDDEN → the next visible pixels are 12'hFF0 and `frame_cnt`=0.
- `rst` pulsed at `vcount`=210 inside the rectangle → outputs are 0 for 2 cycles, then `frame_ypos`=0 until the next `vblnk_start`.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants, colours and types for the draw stages.
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

    localparam logic [11:0] COLOR_RECT_DEF = 12'hFF0;
    localparam logic [11:0] COLOR_END_DEF  = 12'hF00;

    typedef enum logic {
        VISIBLE,
        HIDDEN
    } blink_state_t;

    // One pixel's worth of timing strobes, coordinates and colour.
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        hblnk;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_sig_t;

    // Unsigned min(y, max_y), used to keep the rectangle fully on screen.
    function automatic logic [11:0] clamp_top(input logic [11:0] y, input logic [11:0] max_y);
        return (y > max_y) ? max_y : y;
    endfunction

endpackage

// File: rtl/vga_delay.sv
// Fixed-depth shift register for the VGA timing strobes, counts and colour.
module vga_delay
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    vga_sig_t sig_in;
    vga_sig_t pipe [DEPTH];

    // Bundle the inputs into one record for the shift chain.
    always_comb begin
        sig_in        = '0;
        sig_in.hcount = hcount_in;
        sig_in.vcount = vcount_in;
        sig_in.hsync  = hsync_in;
        sig_in.hblnk  = hblnk_in;
        sig_in.vsync  = vsync_in;
        sig_in.vblnk  = vblnk_in;
        sig_in.rgb    = rgb_in;
    end

    // Shift chain; reset flushes every stage to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= sig_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign hcount_out = pipe[DEPTH-1].hcount;
    assign vcount_out = pipe[DEPTH-1].vcount;
    assign hsync_out  = pipe[DEPTH-1].hsync;
    assign hblnk_out  = pipe[DEPTH-1].hblnk;
    assign vsync_out  = pipe[DEPTH-1].vsync;
    assign vblnk_out  = pipe[DEPTH-1].vblnk;
    assign rgb_out    = pipe[DEPTH-1].rgb;

endmodule

// File: rtl/draw_player_rect.sv
// Composites the player rectangle into the VGA stream; the top row is latched
// once per frame and the rectangle blinks in the end-game colour.
module draw_player_rect
    import vga_pkg::*;
#(
    parameter int unsigned XPOS         = 100,
    parameter int unsigned RECT_W       = 32,
    parameter int unsigned RECT_H       = 24,
    parameter logic [11:0] COLOR_RECT   = COLOR_RECT_DEF,
    parameter logic [11:0] COLOR_END    = COLOR_END_DEF,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] ypos,
    input  logic        endgame,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [11:0] frame_ypos
);

    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [11:0] Y_MAX = 12'(VER_PIXELS - int'(RECT_H));
    localparam logic [11:0] X_LO  = 12'(XPOS);
    localparam logic [11:0] X_HI  = 12'(XPOS + RECT_W - 1);
    localparam logic [11:0] H_M1  = 12'(RECT_H - 1);

    logic             vblnk_prev;
    logic             vblnk_start;
    logic             hit_now;
    logic             hit_s1;
    logic             hit_s2;
    logic             endgame_r;
    logic [11:0]      fill;
    logic [11:0]      rgb_dly;
    logic [CNT_W-1:0] frame_cnt;
    blink_state_t     state;

    assign vblnk_start = vblnk_in & ~vblnk_prev;

    // Latch the clamped top row at the start of vertical blanking only.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev <= 1'b0;
            frame_ypos <= '0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (vblnk_start) begin
                frame_ypos <= clamp_top(ypos, Y_MAX);
            end
        end
    end

    // Stage 1 hit test; the clamp keeps frame_ypos + RECT_H - 1 inside 12 bits.
    always_comb begin
        hit_now = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} <= X_HI)
               && ({1'b0, vcount_in} >= frame_ypos)
               && ({1'b0, vcount_in} <= (frame_ypos + H_M1))
               && !hblnk_in && !vblnk_in;
    end

    // Carry the hit flag alongside the delayed pixel; register endgame for the fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_s1    <= 1'b0;
            hit_s2    <= 1'b0;
            endgame_r <= 1'b0;
        end else begin
            hit_s1    <= hit_now;
            hit_s2    <= hit_s1;
            endgame_r <= endgame;
        end
    end

    // Blink FSM: counts frames while in end-game, toggles on the last one.
    always_ff @(posedge clk) begin
        if (rst || !endgame) begin
            state     <= VISIBLE;
            frame_cnt <= '0;
        end else if (vblnk_start) begin
            if (frame_cnt == CNT_LAST) begin
                frame_cnt <= '0;
                state     <= (state == VISIBLE) ? HIDDEN : VISIBLE;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    vga_delay #(
        .DEPTH(2)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .hcount_in (hcount_in),
        .vcount_in (vcount_in),
        .hsync_in  (hsync_in),
        .hblnk_in  (hblnk_in),
        .vsync_in  (vsync_in),
        .vblnk_in  (vblnk_in),
        .rgb_in    (rgb_in),
        .hcount_out(hcount_out),
        .vcount_out(vcount_out),
        .hsync_out (hsync_out),
        .hblnk_out (hblnk_out),
        .vsync_out (vsync_out),
        .vblnk_out (vblnk_out),
        .rgb_out   (rgb_dly)
    );

    // Stage 2 colour select from registered hit, blink state and fill.
    always_comb begin
        fill    = endgame_r ? COLOR_END : COLOR_RECT;
        rgb_out = (hit_s2 && (state == VISIBLE)) ? fill : rgb_dly;
    end

endmodule

// File: tb/tb_draw_player_rect.sv
// Directed, table-driven bench for draw_player_rect (BLINK_FRAMES = 2).
module tb_draw_player_rect;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] ypos;
    logic        endgame;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [11:0] frame_ypos;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    draw_player_rect #(
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ypos      (ypos),
        .endgame   (endgame),
        .hcount_in (hcount_in),
        .vcount_in (vcount_in),
        .hsync_in  (hsync_in),
        .hblnk_in  (hblnk_in),
        .vsync_in  (vsync_in),
        .vblnk_in  (vblnk_in),
        .rgb_in    (rgb_in),
        .hcount_out(hcount_out),
        .vcount_out(vcount_out),
        .hsync_out (hsync_out),
        .hblnk_out (hblnk_out),
        .vsync_out (vsync_out),
        .vblnk_out (vblnk_out),
        .rgb_out   (rgb_out),
        .frame_ypos(frame_ypos)
    );

    typedef struct {
        logic [11:0] ypos;
        logic [11:0] exp_fy;
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic [11:0] rgb;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [24];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold one pixel for two cycles so the output shows exactly that pixel.
    task automatic check_pix(input string name, input logic [10:0] h, input logic [10:0] v,
                             input logic hb, input logic [11:0] rgb, input logic [11:0] exp);
        hcount_in = h;
        vcount_in = v;
        hblnk_in  = hb;
        vblnk_in  = 1'b0;
        rgb_in    = rgb;
        tick();
        tick();
        chk(name, rgb_out, exp);
    endtask

    task automatic vblank_pulse();
        vblnk_in = 1'b1;
        repeat (3) tick();
        vblnk_in = 1'b0;
        tick();
    endtask

    logic [10:0] s_h   [10];
    logic [11:0] s_exp [10];
    logic [3:0]  s_str [10];
    logic [11:0] last_y;

    initial begin
        // ypos, exp frame_ypos, h, v, hblnk, rgb_in, exp rgb_out
        vecs[0]  = '{12'd200, 12'd200, 11'd99,  11'd200, 1'b0, 12'h123, 12'h123};
        vecs[1]  = '{12'd200, 12'd200, 11'd100, 11'd200, 1'b0, 12'h123, 12'hFF0};
        vecs[2]  = '{12'd200, 12'd200, 11'd131, 11'd200, 1'b0, 12'h456, 12'hFF0};
        vecs[3]  = '{12'd200, 12'd200, 11'd132, 11'd200, 1'b0, 12'h456, 12'h456};
        vecs[4]  = '{12'd200, 12'd200, 11'd100, 11'd223, 1'b0, 12'h789, 12'hFF0};
        vecs[5]  = '{12'd200, 12'd200, 11'd131, 11'd223, 1'b0, 12'h789, 12'hFF0};
        vecs[6]  = '{12'd200, 12'd200, 11'd100, 11'd224, 1'b0, 12'h789, 12'h789};
        vecs[7]  = '{12'd200, 12'd200, 11'd115, 11'd199, 1'b0, 12'h321, 12'h321};
        vecs[8]  = '{12'd200, 12'd200, 11'd115, 11'd212, 1'b1, 12'h654, 12'h654};
        vecs[9]  = '{12'd200, 12'd200, 11'd115, 11'd212, 1'b0, 12'h654, 12'hFF0};
        vecs[10] = '{12'd700, 12'd576, 11'd100, 11'd576, 1'b0, 12'h0F0, 12'hFF0};
        vecs[11] = '{12'd700, 12'd576, 11'd131, 11'd599, 1'b0, 12'h0F0, 12'hFF0};
        vecs[12] = '{12'd700, 12'd576, 11'd131, 11'd575, 1'b0, 12'h0F0, 12'h0F0};
        vecs[13] = '{12'd700, 12'd576, 11'd116, 11'd600, 1'b0, 12'h0F0, 12'h0F0};
        vecs[14] = '{12'd576, 12'd576, 11'd110, 11'd599, 1'b0, 12'h00F, 12'hFF0};
        vecs[15] = '{12'd577, 12'd576, 11'd110, 11'd576, 1'b0, 12'h00F, 12'hFF0};
        vecs[16] = '{12'd0,   12'd0,   11'd100, 11'd0,   1'b0, 12'h111, 12'hFF0};
        vecs[17] = '{12'd0,   12'd0,   11'd100, 11'd23,  1'b0, 12'h111, 12'hFF0};
        vecs[18] = '{12'd0,   12'd0,   11'd100, 11'd24,  1'b0, 12'h111, 12'h111};
        vecs[19] = '{12'd4095, 12'd576, 11'd110, 11'd590, 1'b0, 12'h222, 12'hFF0};
        vecs[20] = '{12'd4095, 12'd576, 11'd99,  11'd590, 1'b0, 12'h222, 12'h222};
        vecs[21] = '{12'd575, 12'd575, 11'd110, 11'd598, 1'b0, 12'h333, 12'hFF0};
        vecs[22] = '{12'd575, 12'd575, 11'd110, 11'd599, 1'b0, 12'h333, 12'h333};
        vecs[23] = '{12'd575, 12'd575, 11'd110, 11'd575, 1'b0, 12'h333, 12'hFF0};

        rst = 1'b1;
        ypos = '0;
        endgame = 1'b0;
        hcount_in = '0;
        vcount_in = '0;
        hsync_in = 1'b0;
        hblnk_in = 1'b0;
        vsync_in = 1'b0;
        vblnk_in = 1'b0;
        rgb_in = '0;
        tick();
        tick();

        // Reset state
        chk("reset rgb_out", rgb_out, 12'h000);
        chk("reset hcount_out", hcount_out, 11'd0);
        chk("reset vcount_out", vcount_out, 11'd0);
        chk("reset strobes", {hsync_out, hblnk_out, vsync_out, vblnk_out}, 4'b0000);
        chk("reset frame_ypos", frame_ypos, 12'd0);
        rst = 1'b0;
        tick();

        // Latch timing: frame_ypos moves one edge after vblnk_in rises
        ypos = 12'd200;
        vblnk_in = 1'b1;
        chk("latch not combinational", frame_ypos, 12'd0);
        tick();
        chk("latch one cycle", frame_ypos, 12'd200);
        ypos = 12'd300;
        tick();
        chk("latch holds in vblank", frame_ypos, 12'd200);
        vblnk_in = 1'b0;
        tick();
        ypos = 12'd200;

        // Table of single-pixel hit tests, re-latching ypos when it changes
        last_y = 12'd200;
        for (int i = 0; i < 24; i++) begin
            if (vecs[i].ypos != last_y) begin
                ypos = vecs[i].ypos;
                vblank_pulse();
                chk($sformatf("vec%0d frame_ypos", i), frame_ypos, vecs[i].exp_fy);
                last_y = vecs[i].ypos;
            end
            check_pix($sformatf("vec%0d rgb", i), vecs[i].h, vecs[i].v, vecs[i].hb,
                      vecs[i].rgb, vecs[i].exp);
        end

        // Streamed pixels across the left edge: 2-cycle alignment of all signals
        ypos = 12'd200;
        vblank_pulse();
        for (int i = 0; i < 10; i++) begin
            s_h[i]   = 11'(96 + i);
            s_str[i] = {i[0], (i == 9), i[1], 1'b0};
            s_exp[i] = (i >= 4 && i != 9) ? 12'hFF0 : 12'(12'h0A0 + i);
        end
        for (int i = 0; i < 10; i++) begin
            hcount_in = s_h[i];
            vcount_in = 11'd210;
            {hsync_in, hblnk_in, vsync_in, vblnk_in} = s_str[i];
            rgb_in = 12'(12'h0A0 + i);
            tick();
            if (i >= 1) begin
                chk($sformatf("stream%0d hcount", i - 1), hcount_out, s_h[i-1]);
                chk($sformatf("stream%0d strobes", i - 1),
                    {hsync_out, hblnk_out, vsync_out, vblnk_out}, s_str[i-1]);
                chk($sformatf("stream%0d rgb", i - 1), rgb_out, s_exp[i-1]);
            end
        end
        hblnk_in = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        tick();
        vblnk_in = 1'b1;
        tick();
        chk("vblnk_out after 1", vblnk_out, 1'b0);
        tick();
        chk("vblnk_out after 2", vblnk_out, 1'b1);
        vblnk_in = 1'b0;
        tick();

        // ypos changes mid-frame: current frame stays at 200
        check_pix("midframe before", 11'd100, 11'd210, 1'b0, 12'h555, 12'hFF0);
        ypos = 12'd300;
        check_pix("midframe after change", 11'd100, 11'd210, 1'b0, 12'h555, 12'hFF0);
        check_pix("midframe new row not drawn", 11'd100, 11'd300, 1'b0, 12'h555, 12'h555);
        chk("midframe frame_ypos", frame_ypos, 12'd200);
        vblank_pulse();
        chk("next frame frame_ypos", frame_ypos, 12'd300);
        check_pix("next frame new row", 11'd100, 11'd300, 1'b0, 12'h555, 12'hFF0);
        check_pix("next frame old row", 11'd100, 11'd210, 1'b0, 12'h555, 12'h555);

        // Blink: two frames visible in end colour, two hidden, and so on
        endgame = 1'b1;
        for (int f = 0; f < 8; f++) begin
            check_pix($sformatf("blink frame%0d", f), 11'd110, 11'd310, 1'b0, 12'h0A5,
                      (((f / 2) % 2) == 0) ? 12'hF00 : 12'h0A5);
            if (f < 7) vblank_pulse();
        end
        chk("hidden frame_cnt", 32'(dut.frame_cnt), 32'd1);
        endgame = 1'b0;
        tick();
        chk("endgame drop frame_cnt", 32'(dut.frame_cnt), 32'd0);
        check_pix("endgame drop colour", 11'd110, 11'd310, 1'b0, 12'h0A5, 12'hFF0);

        // endgame rising together with vblnk_start
        ypos = 12'd250;
        endgame = 1'b1;
        vblnk_in = 1'b1;
        tick();
        chk("simul frame_cnt", 32'(dut.frame_cnt), 32'd1);
        chk("simul frame_ypos", frame_ypos, 12'd250);
        vblnk_in = 1'b0;
        endgame = 1'b0;
        tick();

        // Reset inside the rectangle
        ypos = 12'd200;
        vblank_pulse();
        check_pix("pre-reset in rect", 11'd110, 11'd210, 1'b0, 12'hABC, 12'hFF0);
        rst = 1'b1;
        tick();
        chk("reset cyc1 rgb", rgb_out, 12'h000);
        chk("reset cyc1 hcount", hcount_out, 11'd0);
        chk("reset cyc1 frame_ypos", frame_ypos, 12'd0);
        rst = 1'b0;
        tick();
        chk("reset cyc2 rgb", rgb_out, 12'h000);
        chk("reset cyc2 vcount", vcount_out, 11'd0);
        tick();
        chk("post-reset no rect", rgb_out, 12'hABC);
        chk("post-reset hcount", hcount_out, 11'd110);
        chk("post-reset frame_ypos", frame_ypos, 12'd0);

        // vblnk_in high in the first cycle after reset counts as vblnk_start
        rst = 1'b1;
        ypos = 12'd50;
        vblnk_in = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("first-cycle vblank latch", frame_ypos, 12'd50);
        vblnk_in = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
